// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package wb_arb_pkg;
  localparam int WB_DATA_W     = 32;
  localparam int WB_ADDR_W     = 5;
  localparam int WB_FIFO_DEPTH = 4;
  localparam int WB_PTR_W      = $clog2(WB_FIFO_DEPTH);

  localparam logic [WB_ADDR_W-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] dest;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Long-latency result queue; also exports the destinations of occupied slots
// so the arbiter can answer pending-write hazard queries.
module wb_fifo
  import wb_arb_pkg::*;
#(
  parameter int DEPTH = WB_FIFO_DEPTH,
  parameter int PTR_W = WB_PTR_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  wb_entry_t                  entry,
  input  logic                       pop,
  output wb_entry_t                  head,
  output logic                       full,
  output logic                       empty,
  output logic [PTR_W:0]             count,
  output logic [DEPTH*WB_ADDR_W-1:0] dests,
  output logic [DEPTH-1:0]           vld
);
  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= entry;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      vld[i] = ({1'b0, PTR_W'(i) - rd_ptr} < count);
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_dest
    assign dests[g*WB_ADDR_W +: WB_ADDR_W] = mem[g].dest;
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write port arbiter: pipeline writeback beats queued long results.
// Optional macro WB_ARB_BYPASS_EN lets a long result skip an empty queue.
module regfile_wb_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DATA_WIDTH    = WB_DATA_W,
  parameter int ADDRESS_WIDTH = WB_ADDR_W,
  parameter int FIFO_DEPTH    = WB_FIFO_DEPTH,
  parameter int STARVE_LIMIT  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pipe_wb_en,
  input  logic [ADDRESS_WIDTH-1:0] pipe_wb_dest,
  input  logic [DATA_WIDTH-1:0]    pipe_wb_data,
  input  logic                     lng_valid,
  output logic                     lng_ready,
  input  logic [ADDRESS_WIDTH-1:0] lng_dest,
  input  logic [DATA_WIDTH-1:0]    lng_data,
  input  logic [ADDRESS_WIDTH-1:0] q_addr1,
  input  logic [ADDRESS_WIDTH-1:0] q_addr2,
  output logic                     q_hit1,
  output logic                     q_hit2,
  output logic                     pipe_stall,
  output logic                     rg_wrt_en,
  output logic [ADDRESS_WIDTH-1:0] rg_wrt_dest,
  output logic [DATA_WIDTH-1:0]    rg_wrt_data
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT - 1);

  wb_entry_t                           head;
  wb_entry_t                           push_entry;
  logic                                full;
  logic                                empty;
  logic [PTR_W:0]                      count;
  logic [FIFO_DEPTH*ADDRESS_WIDTH-1:0] dests;
  logic [FIFO_DEPTH-1:0]               vld;
  logic                                pipe_req;
  logic                                push_req;
  logic                                push;
  logic                                pop;
  logic                                bypass;
  logic                                lose;
  logic [CNT_W-1:0]                    starve_cnt;

  function automatic logic pending_hit(
    input logic [ADDRESS_WIDTH-1:0]            addr,
    input logic [FIFO_DEPTH*ADDRESS_WIDTH-1:0] d,
    input logic [FIFO_DEPTH-1:0]               v
  );
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (v[i] && (d[i*ADDRESS_WIDTH +: ADDRESS_WIDTH] == addr)) hit = 1'b1;
    end
    return hit;
  endfunction

  // lng_ready comes from the registered occupancy only, so a same-cycle pop
  // never opens a slot for a push.
  assign lng_ready  = !full;
  assign pipe_req   = pipe_wb_en && (pipe_wb_dest != ZERO_REG);
  assign push_req   = lng_valid && lng_ready && (lng_dest != ZERO_REG);
`ifdef WB_ARB_BYPASS_EN
  assign bypass     = push_req && empty && !pipe_req;
`else
  assign bypass     = 1'b0;
`endif
  assign push       = push_req && !bypass;
  assign pop        = !pipe_req && !empty;
  assign lose       = pipe_req && !empty;
  assign push_entry = '{dest: lng_dest, data: lng_data};

  wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .entry (push_entry),
    .pop   (pop),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count),
    .dests (dests),
    .vld   (vld)
  );

  // Output register stage: stable across the whole cycle for the negedge write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rg_wrt_en   <= 1'b0;
      rg_wrt_dest <= '0;
      rg_wrt_data <= '0;
    end else if (pipe_req) begin
      rg_wrt_en   <= 1'b1;
      rg_wrt_dest <= pipe_wb_dest;
      rg_wrt_data <= pipe_wb_data;
    end else if (!empty) begin
      rg_wrt_en   <= 1'b1;
      rg_wrt_dest <= head.dest;
      rg_wrt_data <= head.data;
    end else if (bypass) begin
      rg_wrt_en   <= 1'b1;
      rg_wrt_dest <= lng_dest;
      rg_wrt_data <= lng_data;
    end else begin
      rg_wrt_en   <= 1'b0;
    end
  end

  // The stall is sticky until the queue head finally drains.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
      pipe_stall <= 1'b0;
    end else begin
      if (pop || empty)                          starve_cnt <= '0;
      else if (lose && (starve_cnt != STARVE_MAX)) starve_cnt <= starve_cnt + 1'b1;

      if (lose && (starve_cnt == STARVE_MAX)) pipe_stall <= 1'b1;
      else if (pop)                           pipe_stall <= 1'b0;
    end
  end

  assign q_hit1 = (q_addr1 != ZERO_REG) &&
                  (pending_hit(q_addr1, dests, vld) || (rg_wrt_en && (rg_wrt_dest == q_addr1)));
  assign q_hit2 = (q_addr2 != ZERO_REG) &&
                  (pending_hit(q_addr2, dests, vld) || (rg_wrt_en && (rg_wrt_dest == q_addr2)));

  // Decode must never let a pipe write overtake a queued write to the same register.
  a_pipe_vs_queue: assert property (@(posedge clk) disable iff (!rst)
    !(pipe_req && pending_hit(pipe_wb_dest, dests, vld)));

  a_count_range: assert property (@(posedge clk) disable iff (!rst)
    count <= (PTR_W+1)'(FIFO_DEPTH));
endmodule
